sha_unit: RTL and testbench

//  Iterative single-block SHA-256 compression core: one round per clock, 64 rounds per pass.

---
 rtl/sha256_pkg.sv | 76 +++++++
 rtl/sha_unit_if.sv | 27 ++
 rtl/sha256_round.sv | 30 +++
 rtl/sha_unit.sv | 84 ++++++++
 tb/tb_sha_unit.sv | 117 +++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, word/state types, round constants, IV and bit functions.
package sha256_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned BLOCK_W  = 512;
    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned N_WORDS  = 16;
    localparam int unsigned ROUND_W  = 6;

    typedef logic [WORD_W-1:0] word_t;

    // Working state; a sits in the MSBs so the packed layout matches H0/H1 word order
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } state_t;

    localparam word_t SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam state_t SHA256_IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha_unit_if.sv
// Bus between the shared round sequencer and one compression unit.
interface sha_unit_if;
    import sha256_pkg::*;

    logic [ROUND_W-1:0]  round;
    word_t               Kt;
    logic [BLOCK_W-1:0]  M;
    logic [DIGEST_W-1:0] H0;
    logic [DIGEST_W-1:0] H1;

    modport master (
        output round,
        output Kt,
        output M,
        output H0,
        input  H1
    );

    modport slave (
        input  round,
        input  Kt,
        input  M,
        input  H0,
        output H1
    );

endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: S' = R(S, Kt, Wt).
module sha256_round
    import sha256_pkg::*;
(
    input  state_t state_i,
    input  word_t  kt_i,
    input  word_t  wt_i,
    output state_t state_o
);

    word_t t1;
    word_t t2;

    // Compression step: two temporaries, then shift the working variables down
    always_comb begin
        t1 = state_i.h + bsig1(state_i.e) + ch(state_i.e, state_i.f, state_i.g) + kt_i + wt_i;
        t2 = bsig0(state_i.a) + maj(state_i.a, state_i.b, state_i.c);
        state_o = '{
            a: t1 + t2,
            b: state_i.a,
            c: state_i.b,
            d: state_i.c,
            e: state_i.d + t1,
            f: state_i.e,
            g: state_i.f,
            h: state_i.g
        };
    end

endmodule

// File: rtl/sha_unit.sv
// Iterative SHA-256 compression core driven by an external shared round sequencer.
// The last round is folded into the combinational output, so H1 carries the digest
// in the cycle where round has wrapped back to 0.
module sha_unit
    import sha256_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    sha_unit_if.slave  bus
);

    state_t state_q;
    state_t state_d;
    state_t state_nxt_c;
    word_t  w_q [N_WORDS];
    word_t  w_d [N_WORDS];
    word_t  w_new_c;
    logic   load_c;
    state_t h0_c;
    logic [DIGEST_W-1:0] h1_c;

    assign load_c  = (bus.round == '0);
    assign h0_c    = state_t'(bus.H0);
    assign w_new_c = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    sha256_round u_round (
        .state_i (state_q),
        .kt_i    (bus.Kt),
        .wt_i    (w_q[0]),
        .state_o (state_nxt_c)
    );

    // Next state: round 0 reloads chaining value and block, otherwise compress and slide schedule
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < int'(N_WORDS); i++) begin
            w_d[i] = w_q[i];
        end
        if (load_c) begin
            state_d = h0_c;
            for (int i = 0; i < int'(N_WORDS); i++) begin
                w_d[i] = bus.M[int'(BLOCK_W) - 1 - int'(WORD_W) * i -: WORD_W];
            end
        end else begin
            state_d = state_nxt_c;
            for (int i = 0; i < int'(N_WORDS) - 1; i++) begin
                w_d[i] = w_q[i + 1];
            end
            w_d[N_WORDS-1] = w_new_c;
        end
    end

    // State and message-schedule registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            for (int i = 0; i < int'(N_WORDS); i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < int'(N_WORDS); i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // Feed-forward adder on the post-round state: eight independent mod-2^32 word sums
    always_comb begin
        h1_c = {
            h0_c.a + state_nxt_c.a,
            h0_c.b + state_nxt_c.b,
            h0_c.c + state_nxt_c.c,
            h0_c.d + state_nxt_c.d,
            h0_c.e + state_nxt_c.e,
            h0_c.f + state_nxt_c.f,
            h0_c.g + state_nxt_c.g,
            h0_c.h + state_nxt_c.h
        };
    end

    assign bus.H1 = h1_c;

endmodule

// File: tb/tb_sha_unit.sv
// Directed bench for sha_unit: the bench acts as the shared round/K sequencer.
module tb_sha_unit;
    import sha256_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sha_unit_if bus ();

    sha_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [255:0] IV = SHA256_IV;

    localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] M_LONG1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] M_LONG2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] H_MID   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] D_LONG  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    // Zero state, zero Wt, Kt = K[63]: only a and e pick up Kt
    localparam logic [255:0] D_RST   = 256'h307b5f59_bb67ae85_3c6ef372_a54ff53a_177fcb71_9b05688c_1f83d9ab_5be0cd19;

    // One sequencer step at the falling edge: Kt follows round by one cycle
    task automatic tick();
        @(negedge clk);
        bus.Kt    = SHA256_K[bus.round];
        bus.round = bus.round + 6'd1;
    endtask

    // Compare all eight H1 words against an expected digest
    task automatic check(input string tag, input logic [255:0] exp_d);
        word_t o_w;
        word_t e_w;
        #1;
        for (int i = 0; i < 8; i++) begin
            o_w = bus.H1[255 - 32 * i -: 32];
            e_w = exp_d[255 - 32 * i -: 32];
            vectors++;
            assert (o_w === e_w) else begin
                miscompares++;
                $error("FAIL %s w%0d: observed %h expected %h", tag, i, o_w, e_w);
            end
        end
    endtask

    // Full pass from round==0: load edge plus 63 compress edges
    task automatic run_pass(input logic [511:0] msg, input logic [255:0] h0);
        bus.M  = msg;
        bus.H0 = h0;
        repeat (64) tick();
    endtask

    initial begin
        bus.round = '0;
        bus.Kt    = SHA256_K[63];
        bus.M     = M_ABC;
        bus.H0    = IV;

        // Reset state with round held at 0
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset", D_RST);
        rst_n = 1'b1;

        // FIPS "abc", then empty message back-to-back, then "abc" again
        run_pass(M_ABC, IV);
        check("abc", D_ABC);
        run_pass(M_EMPTY, IV);
        check("empty_b2b", D_EMPTY);
        run_pass(M_ABC, IV);
        check("abc_b2b", D_ABC);

        // Reset pulse at round 30 while the counter keeps running
        bus.M = M_EMPTY;
        repeat (30) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 64 && bus.round != '0; n++) tick();
        run_pass(M_ABC, IV);
        check("after_reset", D_ABC);

        // Abort at round 40 by forcing the counter to 0
        bus.M = M_EMPTY;
        repeat (40) tick();
        bus.round = '0;
        run_pass(M_ABC, IV);
        check("after_abort", D_ABC);

        // Two-block message: first block from IV, second block from its chaining value
        run_pass(M_LONG1, IV);
        check("long_blk1", H_MID);
        run_pass(M_LONG2, H_MID);
        check("long_blk2", D_LONG);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
